// File: rtl/ca_line_reader.sv
// Line-buffer reader: fetches WORDS 16-bit words from a synchronous line buffer
// and serialises them MSB first as a 1-bit pixel stream, one pixel per pix_en.
// The next word is always prefetched one word ahead so a word boundary never
// stalls, whatever the pix_en pattern.

module ca_line_reader #(
   parameter int unsigned WORDS = 160
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        line_start,
   input  logic        pix_en,
   output logic        rd_en,
   output logic [7:0]  raddr,
   input  logic [15:0] rdata,
   output logic        active,
   output logic        pixel,
   output logic        line_done
);

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StLoad,
      StActive
   } state_e;

   // Index of the final word of a line, widened so WORDS=256 still fits.
   localparam logic [8:0] LastWord  = 9'(WORDS - 1);
   localparam bit         MultiWord = (WORDS > 1);

   state_e      state;
   logic [15:0] sh;
   logic [15:0] next_word;
   logic [7:0]  word_cnt;
   logic [3:0]  bit_cnt;
   logic        rd_pend;

   logic [8:0]  word_ext;
   logic [8:0]  prefetch_addr;
   logic        last_word;
   logic        last_bit;

   // Prefetch target is two words ahead of the word now being shifted out:
   // word_cnt+1 already sits in next_word.
   assign word_ext      = {1'b0, word_cnt};
   assign prefetch_addr = word_ext + 9'd2;
   assign last_word     = (word_ext == LastWord);
   assign last_bit      = (bit_cnt == 4'hF);

   // Pixels are only meaningful while presenting; force 0 otherwise.
   assign active = (state == StActive);
   assign pixel  = active & sh[15];

   // Single FSM: sequencing, read issue, prefetch capture and shifting.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         rd_en     <= 1'b0;
         raddr     <= 8'd0;
         line_done <= 1'b0;
         sh        <= 16'd0;
         next_word <= 16'd0;
         word_cnt  <= 8'd0;
         bit_cnt   <= 4'd0;
         rd_pend   <= 1'b0;
      end else begin
         rd_en     <= 1'b0;
         line_done <= 1'b0;
         // Buffer data lands one cycle after the strobe.
         rd_pend   <= rd_en;
         if (rd_pend) begin
            next_word <= rdata;
         end

         if (line_start) begin
            // Start, or abort and restart, from word 0 in any state.
            state    <= StFetch;
            rd_en    <= 1'b1;
            raddr    <= 8'd0;
            word_cnt <= 8'd0;
            bit_cnt  <= 4'd0;
         end else begin
            unique case (state)
               StIdle: begin
                  state <= StIdle;
               end

               StFetch: begin
                  state <= StLoad;
               end

               StLoad: begin
                  sh    <= rdata;
                  state <= StActive;
                  if (MultiWord) begin
                     rd_en <= 1'b1;
                     raddr <= 8'd1;
                  end
               end

               StActive: begin
                  if (pix_en) begin
                     if (!last_bit) begin
                        sh      <= {sh[14:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end else if (!last_word) begin
                        sh       <= next_word;
                        word_cnt <= word_cnt + 8'd1;
                        bit_cnt  <= 4'd0;
                        // Never read past the end of the line.
                        if (prefetch_addr <= LastWord) begin
                           rd_en <= 1'b1;
                           raddr <= prefetch_addr[7:0];
                        end
                     end else begin
                        state     <= StIdle;
                        line_done <= 1'b1;
                     end
                  end
               end

               default: begin
                  state <= StIdle;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ca_line_reader.sv
// Directed bench for ca_line_reader with a synchronous line-buffer model.

module tb_ca_line_reader;

   localparam int unsigned WORDS  = 160;
   localparam int          PIXELS = 16 * WORDS;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        line_start = 1'b0;
   logic        pix_en = 1'b0;
   logic        rd_en;
   logic [7:0]  raddr;
   logic [15:0] rdata;
   logic        active;
   logic        pixel;
   logic        line_done;

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];

   ca_line_reader #(.WORDS(WORDS)) dut (
      .clk        (clk),
      .rst        (rst),
      .line_start (line_start),
      .pix_en     (pix_en),
      .rd_en      (rd_en),
      .raddr      (raddr),
      .rdata      (rdata),
      .active     (active),
      .pixel      (pixel),
      .line_done  (line_done)
   );

   always #5 clk = ~clk;

   // Synchronous buffer: data valid the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) rdata <= (int'(raddr) < WORDS) ? mem[raddr] : 16'hDEAD;
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_ramp();
      for (int k = 0; k < 256; k++) mem[k] = (k < WORDS) ? 16'(k) : 16'h0;
   endtask

   task automatic test_reset();
      rst = 1'b1; line_start = 1'b0; pix_en = 1'b0;
      cycle();
      cycle();
      checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
      checks++; if (raddr !== 8'd0) begin errors++; $display("FAIL reset_raddr got %0d want 0", raddr); end
      checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", active); end
      checks++; if (pixel !== 1'b0) begin errors++; $display("FAIL reset_pixel got %b want 0", pixel); end
      checks++; if (line_done !== 1'b0) begin errors++; $display("FAIL reset_line_done got %b want 0", line_done); end
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_single_bit();
      int first_act = -1;
      int act_cnt = 0;
      int ones = 0;
      int one_at = -1;
      int done_cnt = 0;
      int done_at = -1;
      logic [8:0] rd0 = 9'h0;
      for (int k = 0; k < 256; k++) mem[k] = 16'h0;
      mem[0] = 16'h8000;
      cycle();
      line_start = 1'b1; pix_en = 1'b1;
      for (int t = 1; t <= 2570; t++) begin
         cycle();
         line_start = 1'b0;
         if (t == 1) rd0 = {rd_en, raddr};
         if (active && first_act < 0) first_act = t;
         if (active) act_cnt++;
         if (pixel) begin ones++; one_at = t; end
         if (line_done) begin done_cnt++; done_at = t; end
      end
      pix_en = 1'b0;
      checks++; if (rd0 !== 9'h100) begin errors++; $display("FAIL sb_first_read got %h want 100", rd0); end
      checks++; if (first_act != 3) begin errors++; $display("FAIL sb_first_active got %0d want 3", first_act); end
      checks++; if (act_cnt != PIXELS) begin errors++; $display("FAIL sb_active_cycles got %0d want %0d", act_cnt, PIXELS); end
      checks++; if (ones != 1) begin errors++; $display("FAIL sb_pixel_ones got %0d want 1", ones); end
      checks++; if (one_at != 3) begin errors++; $display("FAIL sb_pixel_cycle got %0d want 3", one_at); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL sb_done_count got %0d want 1", done_cnt); end
      checks++; if (done_at != 2563) begin errors++; $display("FAIL sb_done_cycle got %0d want 2563", done_at); end
   endtask

   // Ramp line with pix_en at the given duty (percent).
   task automatic test_stream(input int duty);
      int reads [0:255];
      int oob = 0;
      int bad_reads = 0;
      int hold_err = 0;
      int stable_err = 0;
      int consumed = 0;
      int done_cnt = 0;
      int idx;
      logic [7:0] last_addr = 8'd0;
      logic have_addr = 1'b0;
      logic prev_active = 1'b0;
      logic prev_pen = 1'b0;
      logic prev_pix = 1'b0;
      logic [15:0] word = 16'h0;
      for (int k = 0; k < 256; k++) reads[k] = 0;
      fill_ramp();
      cycle();
      line_start = 1'b1; pix_en = 1'b0;
      for (int t = 1; t <= 14000 && done_cnt == 0; t++) begin
         cycle();
         line_start = 1'b0;
         if (rd_en) begin
            if (int'(raddr) >= WORDS) oob++; else reads[raddr]++;
            last_addr = raddr; have_addr = 1'b1;
         end else if (have_addr && raddr !== last_addr) begin
            hold_err++;
         end
         if (line_done) done_cnt++;
         if (prev_active && !prev_pen && active && pixel !== prev_pix) stable_err++;
         pix_en = (duty >= 100) ? 1'b1 : ($urandom_range(0, 99) < duty);
         if (active && pix_en) begin
            consumed++;
            word = {word[14:0], pixel};
            if (consumed % 16 == 0) begin
               idx = consumed / 16 - 1;
               checks++;
               if (word !== 16'(idx)) begin
                  errors++;
                  $display("FAIL duty%0d_word%0d got %h want %h", duty, idx, word, 16'(idx));
               end
            end
         end
         prev_active = active; prev_pen = pix_en; prev_pix = pixel;
      end
      pix_en = 1'b0;
      for (int k = 0; k < int'(WORDS); k++) if (reads[k] != 1) bad_reads++;
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL duty%0d_done got %0d want 1", duty, done_cnt); end
      checks++; if (consumed != PIXELS) begin errors++; $display("FAIL duty%0d_consumed got %0d want %0d", duty, consumed, PIXELS); end
      checks++; if (bad_reads != 0) begin errors++; $display("FAIL duty%0d_read_once got %0d want 0", duty, bad_reads); end
      checks++; if (oob != 0) begin errors++; $display("FAIL duty%0d_oob_reads got %0d want 0", duty, oob); end
      checks++; if (hold_err != 0) begin errors++; $display("FAIL duty%0d_raddr_hold got %0d want 0", duty, hold_err); end
      checks++; if (stable_err != 0) begin errors++; $display("FAIL duty%0d_pixel_hold got %0d want 0", duty, stable_err); end
   endtask

   task automatic test_restart();
      int cons = 0;
      int done_cnt = 0;
      int done_pix = -1;
      int word_err = 0;
      int t_rs = -10;
      logic restarted = 1'b0;
      logic [8:0] rd0 = 9'h0;
      logic [15:0] word = 16'h0;
      fill_ramp();
      cycle();
      line_start = 1'b1; pix_en = 1'b1;
      for (int t = 1; t <= 7000 && done_cnt == 0; t++) begin
         cycle();
         line_start = 1'b0;
         if (t == t_rs + 1) rd0 = {rd_en, raddr};
         if (line_done) begin done_cnt++; done_pix = cons; end
         if (active) begin
            if (!restarted && cons == 1000) begin
               line_start = 1'b1; restarted = 1'b1; t_rs = t; cons = 0;
            end else begin
               cons++;
               word = {word[14:0], pixel};
               if (restarted && cons % 16 == 0 && word !== 16'(cons / 16 - 1)) word_err++;
            end
         end
      end
      pix_en = 1'b0;
      checks++; if (rd0 !== 9'h100) begin errors++; $display("FAIL rs_reread got %h want 100", rd0); end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rs_done_count got %0d want 1", done_cnt); end
      checks++; if (done_pix != PIXELS) begin errors++; $display("FAIL rs_line_pixels got %0d want %0d", done_pix, PIXELS); end
      checks++; if (word_err != 0) begin errors++; $display("FAIL rs_words got %0d want 0", word_err); end
   endtask

   task automatic test_restart_in_load();
      int first_act = -1;
      logic rd2 = 1'b1;
      logic [8:0] rd3 = 9'h0;
      fill_ramp();
      cycle();
      line_start = 1'b1; pix_en = 1'b1;
      for (int t = 1; t <= 8; t++) begin
         cycle();
         line_start = (t == 2);
         if (t == 2) rd2 = rd_en;
         if (t == 3) rd3 = {rd_en, raddr};
         if (active && first_act < 0) first_act = t;
      end
      line_start = 1'b0; pix_en = 1'b0;
      checks++; if (rd2 !== 1'b0) begin errors++; $display("FAIL ld_load_rd_en got %b want 0", rd2); end
      checks++; if (rd3 !== 9'h100) begin errors++; $display("FAIL ld_reread got %h want 100", rd3); end
      checks++; if (first_act != 5) begin errors++; $display("FAIL ld_first_active got %0d want 5", first_act); end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset_midline();
      int cons = 0;
      int done_cnt = 0;
      int rd_cnt = 0;
      logic hit = 1'b0;
      logic act_after = 1'b1;
      fill_ramp();
      cycle();
      line_start = 1'b1; pix_en = 1'b1;
      for (int t = 1; t <= 1000 && !hit; t++) begin
         cycle();
         line_start = 1'b0;
         if (active) begin
            if (cons == 500) begin rst = 1'b1; hit = 1'b1; end else cons++;
         end
      end
      cycle();
      rst = 1'b0;
      act_after = active;
      for (int t = 0; t < 40; t++) begin
         if (line_done) done_cnt++;
         if (rd_en) rd_cnt++;
         cycle();
      end
      pix_en = 1'b0;
      checks++; if (!hit) begin errors++; $display("FAIL rm_reach500 got 0 want 1"); end
      checks++; if (act_after !== 1'b0) begin errors++; $display("FAIL rm_active_drop got %b want 0", act_after); end
      checks++; if (done_cnt != 0) begin errors++; $display("FAIL rm_no_done got %0d want 0", done_cnt); end
      checks++; if (rd_cnt != 0) begin errors++; $display("FAIL rm_no_reads got %0d want 0", rd_cnt); end
      test_single_bit();
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_stream(100);
      test_stream(30);
      test_restart();
      test_restart_in_load();
      test_reset_midline();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
